// File: rtl/popcount_rr_arbiter.sv
// Round-robin arbiter sharing one 12-bit ones-count unit among requesters.
// Returns the count with the requester ID and keeps saturating per-requester totals.
`timescale 1ns/1ps
module popcount_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*12-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [4:0]             rsp_count,
  input  logic                   clr_acc,
  output logic [N_REQ*ACC_W-1:0] acc_total
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_win;
  logic             w_found;
  logic [11:0]      r_op;
  logic [4:0]       w_cnt;
  logic [ACC_W-1:0] r_acc [N_REQ];

  // Downward scan so the closest index after p is the last one written.
  function automatic logic [ID_W:0] f_pick(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  p
  );
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (v[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [4:0] f_ones(input logic [11:0] d);
    logic [4:0] c;
    c = '0;
    for (int b = 0; b < 12; b++) c = c + {4'd0, d[b]};
    return c;
  endfunction

  function automatic logic [ACC_W-1:0] f_sat(
    input logic [ACC_W-1:0] a,
    input logic [4:0]       c
  );
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(c);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign {w_found, w_win} = f_pick(req_valid, r_ptr);
  assign w_cnt = f_ones(r_op);

  // One-hot grant, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && r_state == IDLE && w_found)
      req_ready[w_win] = 1'b1;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_found) w_next = EVAL;
      EVAL: w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Latch operand, winner and round-robin pointer on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_id  <= '0;
      r_ptr <= ID_W'(N_REQ - 1);
    end else if (r_state == IDLE && w_found) begin
      r_op  <= req_data[12*w_win +: 12];
      r_id  <= w_win;
      r_ptr <= w_win;
    end
  end

  // Response register: loaded in EVAL, held until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
    end else if (r_state == EVAL) begin
      rsp_valid <= 1'b1;
      rsp_id    <= r_id;
      rsp_count <= w_cnt;
    end else if (r_state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating totals; a clear coinciding with EVAL keeps only this word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (r_state == EVAL && r_id == ID_W'(i))
          r_acc[i] <= clr_acc ? ACC_W'(w_cnt)
                              : f_sat(r_acc[i], w_cnt);
        else if (clr_acc)
          r_acc[i] <= '0;
      end
    end
  end

  // Flatten totals onto the output bus.
  always_comb begin
    acc_total = '0;
    for (int i = 0; i < N_REQ; i++)
      acc_total[i*ACC_W +: ACC_W] = r_acc[i];
  end

endmodule

// File: tb/tb_popcount_rr_arbiter.sv
// Bench for popcount_rr_arbiter: transaction-level reference model
// compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_popcount_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 16;
  localparam int AMAX = 65535;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*12-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IW-1:0]   rsp_id;
  logic [4:0]      rsp_count;
  logic            clr_acc = 1'b0;
  logic [N*AW-1:0] acc_total;

  int n_cmp = 0;
  int n_bad = 0;

  popcount_rr_arbiter #(.N_REQ(N), .ID_W(IW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_count(rsp_count),
    .clr_acc(clr_acc), .acc_total(acc_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int acc_of(input int i);
    return int'(acc_total[i*AW +: AW]);
  endfunction

  // Reference model: phase 0 waiting, 1 word held, 2 response out.
  int   m_phase = 0;
  int   m_last  = N - 1;
  int   m_op    = 0;
  int   m_id    = 0;
  bit   m_vld   = 0;
  int   m_rid   = 0;
  int   m_cnt   = 0;
  int   m_acc [N] = '{default: 0};

  always @(posedge clk or posedge rst) begin
    int w;
    int ph;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_vld = 0;
      m_rid = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_acc[i] = 0;
    end else begin
      ph = m_phase;
      w = pick(req_valid, m_last);
      if (ph == 0 && w >= 0) begin
        m_op = int'(req_data[12*w +: 12]);
        m_id = w; m_last = w; m_phase = 1;
      end else if (ph == 1) begin
        m_cnt = $countones(m_op[11:0]);
        m_rid = m_id; m_vld = 1; m_phase = 2;
      end else if (ph == 2 && rsp_ready) begin
        m_vld = 0; m_phase = 0;
      end
      if (clr_acc)
        for (int i = 0; i < N; i++) m_acc[i] = 0;
      if (ph == 1) begin
        m_acc[m_id] = m_acc[m_id] + m_cnt;
        if (m_acc[m_id] > AMAX) m_acc[m_id] = AMAX;
      end
    end
  end

  // Per-cycle comparison and grant log.
  int glog[$];
  always @(negedge clk) begin
    int w;
    logic [N-1:0] er;
    er = '0;
    w = pick(req_valid, m_last);
    if (!rst && m_phase == 0 && w >= 0) er[w] = 1'b1;
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, m_vld);
    check("rsp_id", rsp_id, m_rid);
    check("rsp_count", rsp_count, m_cnt);
    for (int i = 0; i < N; i++)
      check("acc_total", acc_of(i), m_acc[i]);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) glog.push_back(i);
  end

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Request one word; returns 1ns after the grant edge.
  task automatic send(input int id, input logic [11:0] d);
    bit got;
    got = 0;
    req_data[12*id +: 12] = d;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: requester %0d not granted", id);
    end
    at_drive();
    req_valid[id] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_ord [5];
    exp_ord = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_acc", acc_total, 0);
    at_drive();
    rst = 1'b0;

    // Test 1: single word 0xFFF
    req_data[11:0] = 12'hFFF;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_req_ready", req_ready, 4'b0001);
    at_drive();
    req_valid = '0;
    at_drive();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_count", rsp_count, 12);
    check("t1_acc0", acc_of(0), 12);

    // Test 2: all requesters contending
    idle_wait();
    rst = 1'b1;
    at_drive();
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < N; i++)
      req_data[12*i +: 12] = 12'h001 << i;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        n++;
        check("t2_rsp_count", rsp_count, 1);
      end
    end
    at_drive();
    req_valid = '0;
    check("t2_responses", n, 8);
    check("t2_glog_len_ok", glog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check("t2_grant_order", glog[i], exp_ord[i]);
    for (int i = 0; i < N; i++)
      check("t2_acc", acc_of(i), 2);

    // Test 3: backpressure hold
    idle_wait();
    rsp_ready = 1'b0;
    req_data[47:36] = 12'h000;
    send(0, 12'hA5A);
    req_valid[3] = 1'b1;
    at_drive();
    repeat (5) begin
      @(negedge clk);
      check("t3_rsp_valid", rsp_valid, 1);
      check("t3_rsp_id", rsp_id, 0);
      check("t3_rsp_count", rsp_count, 6);
      check("t3_req_ready", req_ready, 0);
    end
    at_drive();
    rsp_ready = 1'b1;
    send(3, 12'h000);

    // Test 4: saturation, then clear colliding with EVAL
    idle_wait();
    clr_acc = 1'b1;
    at_drive();
    clr_acc = 1'b0;
    for (int k = 0; k < 5462; k++) send(2, 12'hFFF);
    at_drive();
    check("t4_sat", acc_of(2), 16'hFFFF);
    idle_wait();
    send(2, 12'h00F);
    clr_acc = 1'b1;
    at_drive();
    clr_acc = 1'b0;
    check("t4_clr_acc2", acc_of(2), 4);
    check("t4_clr_acc0", acc_of(0), 0);
    check("t4_clr_acc1", acc_of(1), 0);
    check("t4_clr_acc3", acc_of(3), 0);

    // Test 5: reset while evaluating
    idle_wait();
    send(2, 12'h7FF);
    rst = 1'b1;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_acc", acc_total, 0);
    at_drive();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
    end
    at_drive();
    req_valid = 4'b1010;
    @(negedge clk);
    check("t5_grant", req_ready, 4'b0010);
    at_drive();
    req_valid = '0;

    // Test 6: full sweep from requester 1
    idle_wait();
    for (int v = 0; v < 4096; v++) begin
      send(1, 12'(v));
      if (v == 0) begin
        at_drive();
        check("t6_zero", rsp_count, 0);
      end
    end
    idle_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/popcount_rr_arbiter.md
Name: popcount_rr_arbiter

Overview:
- Shares one 12-bit ones-count unit (LUT_12bit_1s, combinational, count 0..12) between N_REQ requesters using round-robin arbitration.
- Each accepted word is counted; the result is returned with the requester ID over a valid/ready response channel.
- Keeps a saturating per-requester running total of counted ones.
- Sits between the producer blocks and the shared popcount datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, response ID width; must equal clog2(N_REQ).
- ACC_W, 16, width of each per-requester running total.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  request valid, one bit per requester.
- req_data  input  N_REQ*12  request words; requester i occupies bits [12*i+11:12*i].
- req_ready  output  N_REQ  one-hot accept strobe to the granted requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_id  output  ID_W  requester index of the response.
- rsp_count  output  5  ones count of the word, 0..12.
- clr_acc  input  1  synchronous clear of all running totals.
- acc_total  output  N_REQ*ACC_W  running totals; requester i occupies slice i.

Behaviour:
- Reset (async, immediate on rst high):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_count=0.
  - req_ready=0, all acc_total=0, rr_ptr=N_REQ-1.
  - Reset mid-operation discards any latched word or pending response; no handshake completes in that cycle.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Search priority starts at (rr_ptr+1) mod N_REQ, wrapping upward.
  - First requester with req_valid=1 wins: req_ready[win]=1 combinationally, same cycle; all other ready bits stay 0.
  - On that edge: latch the 12-bit operand and the winner ID, set rr_ptr=win, go to EVAL.
  - No valid request: stay in IDLE, req_ready=0, rr_ptr unchanged.
- EVAL:
  - Register the LUT output into rsp_count and the ID into rsp_id.
  - Set rsp_valid=1 and update acc_total[id]; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_count stable until rsp_ready=1.
  - On handshake edge: rsp_valid=0, go to IDLE.
  - No arbitration occurs in EVAL or RESP; req_ready=0 in both.
- Timing:
  - Word accepted at edge T gives rsp_valid=1 after edge T+1.
  - With rsp_ready held 1: rsp_valid drops after edge T+2, and the next accept can occur at edge T+3.
  - Throughput is one word per 3 cycles.
- Accumulator:
  - acc_total[id] = min(acc_total[id] + rsp_count, 2^ACC_W-1); saturates and never wraps.
  - clr_acc=1 zeroes all totals at the edge.
  - If clr_acc coincides with an EVAL update, the result is acc_total[id]=count of the current word and all others 0.
- rsp_ready is ignored unless in RESP.
- req_valid deasserting without a grant is legal; there is no fairness penalty.
- req_data is only sampled on the grant edge.

Test Plan:
1. Reset, then req_valid=0001, data0=12'hFFF, rsp_ready=1:
   - req_ready=0001 in the first IDLE cycle.
   - Two edges later: rsp_valid=1, rsp_id=0, rsp_count=12, acc_total[0]=12.
2. All four requesters valid continuously, data_i=12'h001<<i, rsp_ready=1:
   - Grant order is 0,1,2,3,0.
   - Every rsp_count=1; each acc_total=2 after 8 responses.
3. rsp_ready=0 for 5 cycles during RESP with data=12'hA5A:
   - rsp_valid/rsp_id/rsp_count stay stable with count=6.
   - req_ready stays 0 and no new grant is made until the handshake.
4. Saturation:
   - Requester 2 sends 12'hFFF 5462 times → acc_total[2]=16'hFFFF, not 16'h0008.
   - clr_acc with a coincident EVAL of 12'h00F → acc_total[2]=4, others 0.
5. Assert rst while in EVAL with data 12'h7FF:
   - rsp_valid=0, acc_total all 0, no response is emitted.
   - After reset, req1 and req3 valid → req1 is granted first.
6. Sweep data 0..4095 from requester 1:
   - rsp_count equals the popcount of each word for every value; 0 yields rsp_count=0.
